// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings, state enum and widths for the 32-bit sequenced ALU
package alu_pkg;

  localparam int HALF_W = 16;
  localparam int FULL_W = 32;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

  // SLT is a subtract on the slice; the less bit is derived afterwards
  function automatic logic [2:0] slice_op(input logic [2:0] op);
    return (op == OP_SLT) ? OP_SUB : op;
  endfunction

endpackage

// File: rtl/alu32_seq.sv
// rtl/alu32_seq.sv - 32-bit ALU controller sequencing a shared 16-bit slice over two passes
module alu32_seq
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [FULL_W-1:0] req_a,
  input  logic [FULL_W-1:0] req_b,
  input  logic [2:0]        req_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [FULL_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_overflow,
  output logic              rsp_cout,
  output logic              rsp_err,
  output logic [HALF_W-1:0] alu_a,
  output logic [HALF_W-1:0] alu_b,
  output logic              alu_cin,
  output logic              alu_less,
  output logic [2:0]        alu_op,
  input  logic [HALF_W-1:0] alu_result,
  input  logic              alu_cout,
  input  logic              alu_overflow,
  input  logic              alu_zero
);

  state_e            state;
  logic [FULL_W-1:0] a_r;
  logic [FULL_W-1:0] b_r;
  logic [2:0]        op_r;
  logic [HALF_W-1:0] lo_res;
  logic              c_mid;
  logic              z_lo;
  logic              sub_like;
  logic              less;

  assign req_ready = (state == IDLE);
  assign alu_less  = 1'b0;
  assign sub_like  = (op_r == OP_SUB) || (op_r == OP_SLT);
  assign less      = alu_result[HALF_W-1] ^ alu_overflow;

  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_cin = 1'b0;
    alu_op  = '0;
    case (state)
      LO: begin
        alu_a   = a_r[HALF_W-1:0];
        alu_b   = b_r[HALF_W-1:0];
        alu_cin = sub_like;
        alu_op  = slice_op(op_r);
      end
      HI: begin
        alu_a   = a_r[FULL_W-1:HALF_W];
        alu_b   = b_r[FULL_W-1:HALF_W];
        alu_cin = c_mid;
        alu_op  = slice_op(op_r);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      a_r          <= '0;
      b_r          <= '0;
      op_r         <= '0;
      lo_res       <= '0;
      c_mid        <= 1'b0;
      z_lo         <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_cout     <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_r  <= req_a;
            b_r  <= req_b;
            op_r <= req_op;
            if (op_is_legal(req_op)) begin
              state <= LO;
            end else begin
              rsp_result   <= '0;
              rsp_zero     <= 1'b0;
              rsp_overflow <= 1'b0;
              rsp_cout     <= 1'b0;
              rsp_err      <= 1'b1;
              rsp_valid    <= 1'b1;
              state        <= DONE;
            end
          end
        end
        LO: begin
          lo_res <= alu_result;
          c_mid  <= alu_cout;
          z_lo   <= alu_zero;
          state  <= HI;
        end
        HI: begin
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= DONE;
          case (op_r)
            OP_SLT: begin
              rsp_result   <= {{(FULL_W-1){1'b0}}, less};
              rsp_zero     <= ~less;
              rsp_overflow <= 1'b0;
              rsp_cout     <= alu_cout;
            end
            OP_ADD, OP_SUB: begin
              rsp_result   <= {alu_result, lo_res};
              rsp_zero     <= z_lo & alu_zero;
              rsp_overflow <= alu_overflow;
              rsp_cout     <= alu_cout;
            end
            default: begin
              rsp_result   <= {alu_result, lo_res};
              rsp_zero     <= z_lo & alu_zero;
              rsp_overflow <= 1'b0;
              rsp_cout     <= 1'b0;
            end
          endcase
        end
        DONE: begin
          // Clear the response fields on acceptance so a stale result never lingers
          if (rsp_ready) begin
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_cout     <= 1'b0;
            rsp_err      <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu32_seq.sv
// tb/tb_alu32_seq.sv - directed table-driven bench for alu32_seq with a behavioral 16-bit slice
module tb_alu32_seq;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [2:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_overflow;
  logic        rsp_cout;
  logic        rsp_err;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_cin;
  logic        alu_less;
  logic [2:0]  alu_op;
  logic [15:0] alu_result;
  logic        alu_cout;
  logic        alu_overflow;
  logic        alu_zero;

  int checks = 0;
  int errors = 0;

  alu32_seq dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_overflow(rsp_overflow), .rsp_cout(rsp_cout), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_less(alu_less),
    .alu_op(alu_op), .alu_result(alu_result), .alu_cout(alu_cout),
    .alu_overflow(alu_overflow), .alu_zero(alu_zero)
  );

  // Behavioral slice: op[2] inverts b, arithmetic adds a + b' + cin
  logic [15:0] s_bb;
  logic [16:0] s_sum;
  logic        s_arith;
  always_comb begin
    s_bb         = alu_op[2] ? ~alu_b : alu_b;
    s_sum        = {1'b0, alu_a} + {1'b0, s_bb} + {16'b0, alu_cin};
    s_arith      = (alu_op == 3'b010) || (alu_op == 3'b110);
    alu_result   = '0;
    alu_cout     = 1'b0;
    alu_overflow = 1'b0;
    case (alu_op)
      3'b000:  alu_result = alu_a & alu_b;
      3'b001:  alu_result = alu_a | alu_b;
      default: alu_result = s_sum[15:0];
    endcase
    if (s_arith) begin
      alu_cout     = s_sum[16];
      alu_overflow = (alu_a[15] == s_bb[15]) && (s_sum[15] != alu_a[15]);
    end
    alu_zero = (alu_result == 16'h0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        ov;
    logic        co;
    logic        er;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v);
    int lat;
    logic legal;
    legal = (v.er == 1'b0);
    chk({v.name, " req_ready idle"}, {31'b0, req_ready}, 32'd1);
    req_a     = v.a;
    req_b     = v.b;
    req_op    = v.op;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (legal) begin
      chk({v.name, " lo alu_a"}, {16'b0, alu_a}, {16'b0, v.a[15:0]});
      chk({v.name, " lo alu_cin"}, {31'b0, alu_cin},
          {31'b0, (v.op == 3'b110) || (v.op == 3'b111)});
    end
    lat = 0;
    while (!rsp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (legal && lat == 1)
        chk({v.name, " hi alu_a"}, {16'b0, alu_a}, {16'b0, v.a[31:16]});
    end
    chk({v.name, " latency"}, lat, legal ? 32'd2 : 32'd0);
    chk({v.name, " rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
    chk({v.name, " result"}, rsp_result, v.res);
    chk({v.name, " flags z/ov/co/err"},
        {28'b0, rsp_zero, rsp_overflow, rsp_cout, rsp_err},
        {28'b0, v.z, v.ov, v.co, v.er});
    chk({v.name, " req_ready busy"}, {31'b0, req_ready}, 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({v.name, " rsp_valid after ack"}, {31'b0, rsp_valid}, 32'd0);
    chk({v.name, " req_ready after ack"}, {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    vecs[0]  = '{"add_carry",  3'b010, 32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{"sub_ovf",    3'b110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{"slt_neg",    3'b111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{"slt_pos",    3'b111, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{"and_zero",   3'b000, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{"or_ones",    3'b001, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{"sub_equal",  3'b110, 32'h00050005, 32'h00050005, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{"add_ovf",    3'b010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{"slt_ovfcase",3'b111, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{"add_wrap",   3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{"illegal",    3'b011, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset rsp_result", rsp_result, 32'd0);
    chk("reset alu_a", {16'b0, alu_a}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) run_op(vecs[i]);

    // Illegal op with the consumer stalled: response must stay put
    req_a = 32'h1; req_b = 32'h2; req_op = 3'b100; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("stall rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("stall err/result", {rsp_err, rsp_result[30:0]}, 32'h80000000);
      chk("stall req_ready", {31'b0, req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("stall release req_ready", {31'b0, req_ready}, 32'd1);

    // Reset in the middle of the HI pass discards the operation
    req_a = 32'h11112222; req_b = 32'h33334444; req_op = 3'b010; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre-reset hi alu_a", {16'b0, alu_a}, 32'h00001111);
    reset = 1'b1;
    #1;
    chk("async reset req_ready", {31'b0, req_ready}, 32'd1);
    chk("async reset alu_a", {16'b0, alu_a}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("post-reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("post-reset req_ready", {31'b0, req_ready}, 32'd1);
    run_op('{"add_2_3", 3'b010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu32_seq.md
# alu32_seq

Multi-cycle controller that performs 32-bit ALU operations by sequencing one shared 16-bit ALU slice over two passes, low half then high half, with the carry chained between passes. It sits between an instruction-side requester and the 16-bit ALU datapath. It owns operand capture, carry chaining, SLT/overflow/zero derivation and the valid/ready handshakes on both sides. The slice is instantiated by the parent; this block only drives and samples its ports.

## Interface
Parameters: none; width fixed at 32 (two 16-bit passes).

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; forces IDLE
- req_valid  in  1  request present
- req_ready  out  1  block can accept (high only in IDLE)
- req_a, req_b  in  32  operands
- req_op  in  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT; others illegal
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_result  out  32  result
- rsp_zero  out  1  rsp_result == 0
- rsp_overflow  out  1  signed overflow (ADD/SUB only, else 0)
- rsp_cout  out  1  carry out of bit 31 (ADD/SUB/SLT, else 0)
- rsp_err  out  1  illegal op
- alu_a, alu_b  out  16  slice operands
- alu_cin  out  1  slice carry-in
- alu_less  out  1  tied 0
- alu_op  out  3  slice op
- alu_result  in  16  slice result
- alu_cout, alu_overflow, alu_zero  in  1  slice flags (alu_set unused)

## Operation
- States: IDLE, LO, HI, DONE.
- IDLE: req_ready=1. A req_valid & req_ready handshake captures a, b and op.
  - Legal op: go to LO.
  - Illegal op: go to DONE with result=0, err=1 and all other flags 0.
- LO: drive alu_a=a[15:0], alu_b=b[15:0].
  - alu_op = op, except SLT drives 110.
  - alu_cin = 1 for SUB/SLT, else 0.
  - Register lo_res=alu_result, c_mid=alu_cout, z_lo=alu_zero. Go to HI.
- HI: drive alu_a=a[31:16], alu_b=b[31:16], same alu_op mapping, alu_cin=c_mid.
  - Register hi_res, cout and ovf from the slice. Go to DONE.
- Result assembly, registered at the HI→DONE transition:
  - AND/OR/ADD/SUB: result={hi_res,lo_res}, zero=z_lo & alu_zero.
  - SLT: result={31'b0, hi_res[15]^ovf}, zero = !(hi_res[15]^ovf). overflow forced 0; cout kept.
  - AND/OR: cout=0 and overflow=0.
- DONE: rsp_valid=1 and outputs held stable until rsp_ready. rsp_valid & rsp_ready moves to IDLE.
- Outside LO/HI: alu_* outputs driven 0.
- Requests arriving while not IDLE are not accepted. The requester must hold req_valid and its operands until req_ready.

## Timing
- Reset (async, any state, including mid-pass): state=IDLE, all rsp_* = 0, alu_* = 0, internal registers cleared, req_ready=1. An in-flight operation is discarded with no response.
- Legal op latency: handshake at edge N; LO in cycle N+1, HI in N+2; rsp_valid high from N+3.
- Illegal op: rsp_valid high from N+1.
- Response handshake at edge M: rsp_valid=0 and req_ready=1 in cycle M+1. Earliest next accept is at edge M+1.
- Minimum sustained throughput: one legal op per 4 cycles.
- rsp_ready held high before DONE: the response completes in its first DONE cycle.
- The slice is combinational. Its outputs are sampled at the end of the same LO/HI cycle, so there is no slice pipeline stage.

## Structure
- Shared package alu_pkg holds:
  - op encodings OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT
  - the state enum (IDLE/LO/HI/DONE)
  - constants HALF_W=16 and FULL_W=32
- No sub-module required; this is a single FSM plus datapath registers.
- Test bench pairs the block with the 16-bit slice, or with a behavioral slice model.

## Test plan
- ADD 0x0000FFFF + 0x00000001 → result 0x00010000; carry chained (c_mid=1); cout=0, ovf=0, zero=0; rsp_valid 3 cycles after accept.
- SUB 0x80000000 − 0x00000001 → result 0x7FFFFFFF, overflow=1, cout=1.
- SLT a=0xFFFFFFFF (−1), b=0x00000001 → result 1. Swapped operands → result 0 with zero=1.
- AND 0xF0F0F0F0 & 0x0F0F0F0F → 0, zero=1. OR of the same → 0xFFFFFFFF, zero=0; cout=0 for both.
- Illegal op 011 → rsp_valid next cycle, err=1, result 0. Also hold rsp_ready=0 for 5 cycles: outputs stable, req_ready=0 throughout.
- Assert reset during HI → next cycle IDLE, rsp_valid=0, req_ready=1. A new ADD 2+3 then returns 5.
